display_share_arbiter: RTL

DISPLAY_SHARE_ARBITER -- requirements
Module: display_share_arbiter

---
 rtl/display_share_arbiter_pkg.sv | 9 +
 rtl/display_share_arbiter_rr_pick.sv | 40 ++++
 rtl/display_share_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/display_share_arbiter_pkg.sv
// Shared display package: ownership FSM state encoding.
package display_share_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first requester after i_last,
// wrapping from the top client back to client 0.
module rr_pick
  import display_share_arbiter_pkg::*;
#(
  parameter int n_clients = 3,
  parameter int IDX_W     = $clog2(n_clients)
) (
  input  logic [n_clients-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [n_clients-1:0] o_pick,
  output logic                 o_valid
);

  int w_d;
  int w_best_d;
  int w_best_i;

  // Smallest rotational distance from the client after i_last wins.
  always_comb begin
    w_d      = 0;
    w_best_d = n_clients;
    w_best_i = 0;
    for (int i = 0; i < n_clients; i++) begin
      if (i_req[i]) begin
        w_d = (i + 2 * n_clients - 1 - int'(i_last)) % n_clients;
        if (w_d < w_best_d) begin
          w_best_d = w_d;
          w_best_i = i;
        end
      end
    end
    o_valid = |i_req;
    o_pick  = '0;
    for (int i = 0; i < n_clients; i++) begin
      if (o_valid && (w_best_i == i)) o_pick[i] = 1'b1;
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Shares one seven-segment display between n_clients requesters. An owner
// keeps the display for at least hold_cycles while it requests; after that a
// waiting client takes over directly, round-robin.
module display_share_arbiter
  import display_share_arbiter_pkg::*;
#(
  parameter int n_clients = 3,
  parameter int w_digit   = 2,
  parameter int clk_mhz   = 50,
  parameter int hold_ms   = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [n_clients-1:0]           req,
  input  logic [n_clients*w_digit*4-1:0] number,
  input  logic [n_clients*w_digit-1:0]   dots,
  output logic [n_clients-1:0]           grant,
  output logic [w_digit*4-1:0]           number_out,
  output logic [w_digit-1:0]             dots_out,
  output logic                           idle
);

  localparam int unsigned HOLD_CYCLES = clk_mhz * 1000 * hold_ms;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam int IDX_W = $clog2(n_clients);
  localparam int DW    = w_digit * 4;

  disp_state_e            r_state, w_state_nxt;
  logic [n_clients-1:0]   r_grant, w_grant_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]       r_last, w_last_nxt;

  logic [n_clients-1:0]   w_pick_req;
  logic [n_clients-1:0]   w_pick;
  logic                   w_pick_vld;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_owner_req;
  logic                   w_sat;

  // While owning, the owner itself is never a successor candidate; r_last is
  // the current owner then, so the scan starts just after it.
  assign w_pick_req  = (r_state == ST_OWN) ? (req & ~r_grant) : req;
  assign w_owner_req = |(req & r_grant);
  assign w_sat       = (r_cnt == CNT_MAX);
  assign grant       = r_grant;

  rr_pick #(
    .n_clients (n_clients),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  // One-hot pick to index, remembered as the round-robin pointer.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < n_clients; i++) begin
      if (w_pick[i]) w_pick_idx = IDX_W'(i);
    end
  end

  // State register: owner, hold counter and pointer; reset points at the top
  // client so client 0 is scanned first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_last  <= IDX_W'(n_clients - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next state: grant from idle, release on drop, hand over after the hold.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_last_nxt  = w_pick_idx;
        end
      end
      ST_OWN: begin
        if (!w_owner_req || (w_sat && w_pick_vld)) begin
          if (w_pick_vld) begin
            w_grant_nxt = w_pick;
            w_cnt_nxt   = '0;
            w_last_nxt  = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end else if (!w_sat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: steer the owner's digits/dots to the driver, zero when idle.
  always_comb begin
    number_out = '0;
    dots_out   = '0;
    for (int i = 0; i < n_clients; i++) begin
      if (r_grant[i]) begin
        number_out = number_out | number[i*DW +: DW];
        dots_out   = dots_out | dots[i*w_digit +: w_digit];
      end
    end
    idle = (r_state == ST_IDLE);
  end

endmodule
